// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls, flushes and memory-wait freezes, plus a saturating lost-cycle counter.
// Define FORWARDING_EN to build for a forwarding datapath (only load-use hazards stall).
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [3:0]  id_src1,
  input  logic [3:0]  id_src2,
  input  logic        id_two_src,
  input  logic [3:0]  exe_dest,
  input  logic        exe_wb_en,
  input  logic        exe_mem_r_en,
  input  logic [3:0]  mem_dest,
  input  logic        mem_wb_en,
  input  logic        mem_busy,
  input  logic        branch_taken,
  input  logic        cnt_clr,
  output logic        pc_freeze,
  output logic        ifid_freeze,
  output logic        idex_bubble,
  output logic        if_flush,
  output logic        freeze_all,
  output logic        fwd_en,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    HAZ   = 2'b01,
    MEMW  = 2'b10,
    FLUSH = 2'b11
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic        exe_match, mem_match, haz_raw, haz, stall_any;

  assign exe_match = (exe_dest == id_src1) | (id_two_src & (exe_dest == id_src2));
  assign mem_match = (mem_dest == id_src1) | (id_two_src & (mem_dest == id_src2));

`ifdef FORWARDING_EN
  assign haz_raw = id_valid & exe_wb_en & exe_mem_r_en & exe_match;
  assign fwd_en  = 1'b1;
`else
  assign haz_raw = id_valid & ((exe_wb_en & exe_match) | (mem_wb_en & mem_match));
  assign fwd_en  = 1'b0;
  logic unused_mem_r_en;
  assign unused_mem_r_en = exe_mem_r_en;
`endif

  // ID holds a bubble during FLUSH, so no real source registers exist there.
  assign haz = haz_raw & (state_reg != FLUSH);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= RUN;
      cnt_reg   <= 16'h0000;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Priority mem_busy > branch_taken > hazard holds in every state; MEMW only
  // differs in that a busy memory masks everything else, which the order already gives.
  always_comb begin
    state_next  = state_reg;
    pc_freeze   = 1'b0;
    ifid_freeze = 1'b0;
    idex_bubble = 1'b0;
    if_flush    = 1'b0;
    freeze_all  = 1'b0;
    if (!rst) begin
      state_next = RUN;
    end else if (mem_busy) begin
      freeze_all = 1'b1;
      state_next = MEMW;
    end else if (branch_taken) begin
      if_flush    = 1'b1;
      idex_bubble = 1'b1;
      state_next  = FLUSH;
    end else if (haz) begin
      pc_freeze   = 1'b1;
      ifid_freeze = 1'b1;
      idex_bubble = 1'b1;
      state_next  = HAZ;
    end else begin
      state_next = RUN;
    end
  end

  assign stall_any = pc_freeze | freeze_all | if_flush;

  always_comb begin
    cnt_next = cnt_reg;
    if (cnt_clr)
      cnt_next = 16'h0000;
    else if (stall_any && cnt_reg != 16'hFFFF)
      cnt_next = cnt_reg + 16'd1;
  end

  assign state     = state_reg;
  assign stall_cnt = cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; expectations follow FORWARDING_EN when defined.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_two_src;
  logic [3:0]  id_src1, id_src2, exe_dest, mem_dest;
  logic        exe_wb_en, exe_mem_r_en, mem_wb_en;
  logic        mem_busy, branch_taken, cnt_clr;
  logic        pc_freeze, ifid_freeze, idex_bubble, if_flush, freeze_all, fwd_en;
  logic [1:0]  state;
  logic [15:0] stall_cnt;

  int tests = 0;
  int fails = 0;

`ifdef FORWARDING_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .mem_busy(mem_busy), .branch_taken(branch_taken), .cnt_clr(cnt_clr),
    .pc_freeze(pc_freeze), .ifid_freeze(ifid_freeze), .idex_bubble(idex_bubble),
    .if_flush(if_flush), .freeze_all(freeze_all), .fwd_en(fwd_en),
    .state(state), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_two_src = 0; id_src1 = 0; id_src2 = 0;
    exe_dest = 0; exe_wb_en = 0; exe_mem_r_en = 0;
    mem_dest = 0; mem_wb_en = 0;
    mem_busy = 0; branch_taken = 0; cnt_clr = 0;
  endtask

  // Load-use on src1: a hazard in both build configurations.
  task automatic load_use();
    id_valid = 1; id_src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1; exe_mem_r_en = 1;
  endtask

  initial begin
    idle();
    rst = 0;
    load_use(); mem_busy = 1; branch_taken = 1;
    cyc(); cyc(); #2;
    check("rst_freeze_all", freeze_all, 0);
    check("rst_if_flush", if_flush, 0);
    check("rst_pc_freeze", pc_freeze, 0);
    check("rst_idex_bubble", idex_bubble, 0);
    check("rst_state", state, 2'b00);
    check("rst_cnt", stall_cnt, 0);

    cyc(); rst = 1; idle(); #2;
    check("run_idle_pc_freeze", pc_freeze, 0);
    check("fwd_en", fwd_en, FWD);

    // load-use stall, then HAZ and one counted cycle
    cyc(); load_use(); #2;
    check("lu_pc_freeze", pc_freeze, 1);
    check("lu_ifid_freeze", ifid_freeze, 1);
    check("lu_idex_bubble", idex_bubble, 1);
    check("lu_freeze_all", freeze_all, 0);
    cyc(); idle(); #2;
    check("lu_state_haz", state, 2'b01);
    check("lu_cnt", stall_cnt, 1);
    check("haz_clear_pc_freeze", pc_freeze, 0);
    cyc(); #2;
    check("haz_back_run", state, 2'b00);

    // EXE writer that is not a load
    cyc(); idle(); id_valid = 1; id_src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1; #2;
    check("exe_nonload_stall", pc_freeze, !FWD);

    // MEM writer matching src2
    cyc(); idle(); id_valid = 1; id_src2 = 4'd5; id_two_src = 1; mem_dest = 4'd5; mem_wb_en = 1; #2;
    check("mem_src2_stall", pc_freeze, !FWD);
    id_two_src = 0; #2;
    check("mem_src2_unused", pc_freeze, 0);

    // mem_busy dominates branch and hazard for 4 cycles
    cyc(); idle(); load_use(); branch_taken = 1; mem_busy = 1; #2;
    check("mw1_freeze_all", freeze_all, 1);
    check("mw1_if_flush", if_flush, 0);
    check("mw1_pc_freeze", pc_freeze, 0);
    for (int k = 2; k <= 4; k++) begin
      cyc(); #2;
      check($sformatf("mw%0d_freeze_all", k), freeze_all, 1);
      check($sformatf("mw%0d_if_flush", k), if_flush, 0);
      check($sformatf("mw%0d_pc_freeze", k), pc_freeze, 0);
      check($sformatf("mw%0d_state", k), state, 2'b10);
    end
    cyc(); mem_busy = 0; #2;
    check("mw5_freeze_all", freeze_all, 0);
    check("mw5_if_flush", if_flush, 1);
    check("mw5_idex_bubble", idex_bubble, 1);
    check("mw5_pc_freeze", pc_freeze, 0);
    cyc(); branch_taken = 0; #2;
    check("fl_state", state, 2'b11);
    check("fl_no_stall", pc_freeze, 0);
    check("fl_no_flush", if_flush, 0);
    cyc(); #2;
    check("fl_to_run", state, 2'b00);
    check("run_h_stall", pc_freeze, 1);
    branch_taken = 1; #2;
    check("br_if_flush", if_flush, 1);
    check("br_idex_bubble", idex_bubble, 1);
    check("br_pc_freeze", pc_freeze, 0);
    cyc(); #2;
    check("refl_state", state, 2'b11);
    check("refl_if_flush", if_flush, 1);
    cyc(); idle(); #2;
    check("refl_stay", state, 2'b11);
    cyc(); #2;
    check("refl_exit", state, 2'b00);

    // counter: clear, fill to saturation, clear under a stall
    cyc(); load_use(); cnt_clr = 1; #2;
    check("cnt_stall_on", pc_freeze, 1);
    cyc(); cnt_clr = 0; #2;
    check("cnt_cleared", stall_cnt, 0);
    repeat (65534) cyc();
    #2;
    check("cnt_fffe", stall_cnt, 16'hFFFE);
    repeat (3) cyc();
    #2;
    check("cnt_sat", stall_cnt, 16'hFFFF);
    cnt_clr = 1;
    cyc(); cnt_clr = 0; idle(); #2;
    check("cnt_clr_wins", stall_cnt, 0);

    // reset in the middle of a memory wait
    cyc(); mem_busy = 1; #2;
    check("rmw_freeze_all", freeze_all, 1);
    cyc(); #2;
    check("rmw_state", state, 2'b10);
    rst = 0; #2;
    check("rmw_rst_freeze_all", freeze_all, 0);
    cyc(); rst = 1; mem_busy = 0; #2;
    check("rmw_state_run", state, 2'b00);
    check("rmw_cnt_zero", stall_cnt, 0);
    cyc(); #2;
    check("post_rst_cnt", stall_cnt, 0);
    check("post_rst_state", state, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
